// File: rtl/fetch_pc_ctrl.sv
// Fetch-stage PC controller: steps the fetch PC from the predictor, hands slots to decode,
// and turns execute-stage branch resolutions into redirects, predictor updates and counters.
module fetch_pc_ctrl #(
    parameter int                  PC_WIDTH  = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC  = 32'h0000_0000,
    parameter int                  CNT_WIDTH = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    output logic [PC_WIDTH-1:0]  o_pc,
    input  logic                 i_pred_taken,
    input  logic [PC_WIDTH-1:0]  i_pred_next_pc,
    output logic                 o_fetch_vld,
    input  logic                 i_fetch_rdy,
    output logic                 o_fetch_pred_taken,
    output logic [PC_WIDTH-1:0]  o_fetch_pred_pc,
    input  logic                 i_res_vld,
    input  logic                 i_res_is_br,
    input  logic                 i_res_is_jmp,
    input  logic [PC_WIDTH-1:0]  i_res_pc,
    input  logic                 i_res_taken,
    input  logic [PC_WIDTH-1:0]  i_res_target,
    input  logic [PC_WIDTH-1:0]  i_res_pred_pc,
    output logic                 o_flush,
    output logic                 o_upd_btb_vld,
    output logic [PC_WIDTH-1:0]  o_upd_btb_pc,
    output logic [PC_WIDTH-1:0]  o_upd_btb_br_addr,
    output logic                 o_upd_pht_vld,
    output logic [PC_WIDTH-1:0]  o_upd_pht_pc,
    output logic                 o_upd_pht_taken,
    output logic [CNT_WIDTH-1:0] o_br_cnt,
    output logic [CNT_WIDTH-1:0] o_mispred_cnt
);

    // Handshake: a fetch slot transfers to decode on a cycle where o_fetch_vld and
    // i_fetch_rdy are both high; the PC only advances on such a transfer or on a redirect.

    logic                ctl;
    logic                act_taken;
    logic [PC_WIDTH-1:0] act_next;
    logic                mispred;
    logic [PC_WIDTH-1:0] pc_q;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    always_comb begin
        ctl       = i_res_vld & (i_res_is_br | i_res_is_jmp);
        act_taken = i_res_is_jmp | i_res_taken;
        act_next  = act_taken ? i_res_target : i_res_pc + PC_WIDTH'(4);
        mispred   = ctl & (act_next != i_res_pred_pc);
    end

    assign o_pc               = pc_q;
    assign o_fetch_vld        = ~i_rst & ~mispred;
    assign o_flush            = mispred;
    assign o_fetch_pred_taken = i_pred_taken;
    assign o_fetch_pred_pc    = i_pred_next_pc;

    // Redirect wins over a stalled or accepted fetch slot.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pc_q <= RESET_PC;
        end else if (mispred) begin
            pc_q <= act_next;
        end else if (o_fetch_vld && i_fetch_rdy) begin
            pc_q <= i_pred_next_pc;
        end
    end

    // Predictor update ports: one-cycle pulses, payload captured unconditionally.
    always_ff @(posedge i_clk) begin
        o_upd_btb_pc      <= i_res_pc;
        o_upd_btb_br_addr <= i_res_target;
        o_upd_pht_pc      <= i_res_pc;
        o_upd_pht_taken   <= i_res_taken;
        if (i_rst) begin
            o_upd_btb_vld <= 1'b0;
            o_upd_pht_vld <= 1'b0;
        end else begin
            o_upd_btb_vld <= ctl & act_taken & (i_res_pred_pc != i_res_target);
            o_upd_pht_vld <= ctl & i_res_is_br & ~i_res_is_jmp;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_br_cnt      <= '0;
            o_mispred_cnt <= '0;
        end else begin
            if (ctl && (o_br_cnt != CNT_MAX)) begin
                o_br_cnt <= o_br_cnt + CNT_WIDTH'(1);
            end
            if (mispred && (o_mispred_cnt != CNT_MAX)) begin
                o_mispred_cnt <= o_mispred_cnt + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Bench for fetch_pc_ctrl: directed scenarios with literal expectations, then random
// traffic checked every cycle against a behavioural model of the fetch/resolve rules.
module tb_fetch_pc_ctrl;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   o_pc;
    logic          pred_taken;
    logic          pred_follow;
    logic [31:0]   pred_drv;
    logic [31:0]   pred_next_pc;
    logic          fetch_vld;
    logic          fetch_rdy;
    logic          fetch_pred_taken;
    logic [31:0]   fetch_pred_pc;
    logic          res_vld, res_is_br, res_is_jmp, res_taken;
    logic [31:0]   res_pc, res_target, res_pred_pc;
    logic          flush;
    logic          btb_vld, pht_vld, pht_taken;
    logic [31:0]   btb_pc, btb_addr, pht_pc;
    logic [CW-1:0] br_cnt, mis_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Predictor stand-in: either sequential (pc+4, combinational on o_pc) or a driven value.
    assign pred_next_pc = pred_follow ? o_pc + 32'd4 : pred_drv;

    fetch_pc_ctrl #(.PC_WIDTH(32), .RESET_PC(32'h0000_0000), .CNT_WIDTH(CW)) dut (
        .i_clk(clk), .i_rst(rst), .o_pc(o_pc),
        .i_pred_taken(pred_taken), .i_pred_next_pc(pred_next_pc),
        .o_fetch_vld(fetch_vld), .i_fetch_rdy(fetch_rdy),
        .o_fetch_pred_taken(fetch_pred_taken), .o_fetch_pred_pc(fetch_pred_pc),
        .i_res_vld(res_vld), .i_res_is_br(res_is_br), .i_res_is_jmp(res_is_jmp),
        .i_res_pc(res_pc), .i_res_taken(res_taken), .i_res_target(res_target),
        .i_res_pred_pc(res_pred_pc), .o_flush(flush),
        .o_upd_btb_vld(btb_vld), .o_upd_btb_pc(btb_pc), .o_upd_btb_br_addr(btb_addr),
        .o_upd_pht_vld(pht_vld), .o_upd_pht_pc(pht_pc), .o_upd_pht_taken(pht_taken),
        .o_br_cnt(br_cnt), .o_mispred_cnt(mis_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic is_ctl();
        return res_vld && (res_is_br || res_is_jmp);
    endfunction

    function automatic logic [31:0] where_next();
        if (res_is_jmp || res_taken) return res_target;
        return res_pc + 32'd4;
    endfunction

    function automatic logic is_mis();
        return is_ctl() && (where_next() != res_pred_pc);
    endfunction

    logic [31:0]   m_pc;
    logic [CW-1:0] m_br, m_mis;
    logic          m_btb_vld, m_pht_vld, m_pht_taken;
    logic [31:0]   m_btb_pc, m_btb_addr, m_pht_pc;
    logic          started = 1'b0;

    always @(posedge clk) begin
        started <= 1'b1;
        if (rst) begin
            m_pc      <= 32'h0;
            m_br      <= '0;
            m_mis     <= '0;
            m_btb_vld <= 1'b0;
            m_pht_vld <= 1'b0;
        end else begin
            if (is_mis())       m_pc <= where_next();
            else if (fetch_rdy) m_pc <= pred_next_pc;
            if (is_ctl() && m_br != 4'hF)  m_br  <= m_br + 4'd1;
            if (is_mis() && m_mis != 4'hF) m_mis <= m_mis + 4'd1;
            m_btb_vld   <= is_ctl() && (res_is_jmp || res_taken) && (res_pred_pc != res_target);
            m_btb_pc    <= res_pc;
            m_btb_addr  <= res_target;
            m_pht_vld   <= is_ctl() && res_is_br && !res_is_jmp;
            m_pht_pc    <= res_pc;
            m_pht_taken <= res_taken;
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            check("pc", o_pc, m_pc);
            check("fetch_vld", 32'(fetch_vld), 32'(!rst && !is_mis()));
            check("flush", 32'(flush), 32'(is_mis()));
            check("pred_pc_sb", fetch_pred_pc, pred_next_pc);
            check("pred_taken_sb", 32'(fetch_pred_taken), 32'(pred_taken));
            check("btb_vld", 32'(btb_vld), 32'(m_btb_vld));
            if (m_btb_vld) begin
                check("btb_pc", btb_pc, m_btb_pc);
                check("btb_addr", btb_addr, m_btb_addr);
            end
            check("pht_vld", 32'(pht_vld), 32'(m_pht_vld));
            if (m_pht_vld) begin
                check("pht_pc", pht_pc, m_pht_pc);
                check("pht_taken", 32'(pht_taken), 32'(m_pht_taken));
            end
            check("br_cnt", 32'(br_cnt), 32'(m_br));
            check("mis_cnt", 32'(mis_cnt), 32'(m_mis));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_res();
        res_vld = 0; res_is_br = 0; res_is_jmp = 0; res_taken = 0;
        res_pc = '0; res_target = '0; res_pred_pc = '0;
    endtask

    task automatic drive_res(input logic br, input logic jmp, input logic [31:0] pc,
                             input logic tk, input logic [31:0] tgt, input logic [31:0] ppc);
        res_vld = 1; res_is_br = br; res_is_jmp = jmp; res_pc = pc;
        res_taken = tk; res_target = tgt; res_pred_pc = ppc;
    endtask

    logic [1:0] sel;

    initial begin
        rst = 1; fetch_rdy = 1; pred_follow = 1; pred_drv = '0; pred_taken = 0;
        clear_res();

        // Reset values
        tick(); tick(); #3;
        check("rst_pc", o_pc, 32'h0);
        check("rst_vld", 32'(fetch_vld), 32'h0);
        check("rst_flush", 32'(flush), 32'h0);
        check("rst_btb_vld", 32'(btb_vld), 32'h0);
        check("rst_pht_vld", 32'(pht_vld), 32'h0);
        check("rst_br_cnt", 32'(br_cnt), 32'h0);

        // Sequential fetch 0,4,8,12
        tick(); rst = 0; #3;
        check("seq_vld", 32'(fetch_vld), 32'h1);
        check("seq_pc0", o_pc, 32'h0);
        tick(); #3; check("seq_pc1", o_pc, 32'h4);
        tick(); #3; check("seq_pc2", o_pc, 32'h8);
        tick(); #3; check("seq_pc3", o_pc, 32'hC);

        // Stall three cycles at 0x10, then release to a driven predictor target
        tick();
        for (int i = 0; i < 3; i++) begin
            fetch_rdy = 0; #3;
            check("stall_pc", o_pc, 32'h10);
            tick();
        end
        fetch_rdy = 1; pred_follow = 0; pred_drv = 32'h200; pred_taken = 1; #3;
        check("stall_hold", o_pc, 32'h10);
        check("stall_sb_pc", fetch_pred_pc, 32'h200);
        check("stall_sb_tk", 32'(fetch_pred_taken), 32'h1);
        tick(); pred_follow = 1; pred_taken = 0; #3;
        check("release_pc", o_pc, 32'h200);

        // Mispredicted taken branch at 0x20 -> 0x80
        drive_res(1, 0, 32'h20, 1, 32'h80, 32'h24); #1;
        check("br_flush", 32'(flush), 32'h1);
        check("br_vld_low", 32'(fetch_vld), 32'h0);
        tick(); clear_res(); #3;
        check("br_redirect", o_pc, 32'h80);
        check("br_btb_vld", 32'(btb_vld), 32'h1);
        check("br_btb_pc", btb_pc, 32'h20);
        check("br_btb_addr", btb_addr, 32'h80);
        check("br_pht_vld", 32'(pht_vld), 32'h1);
        check("br_pht_pc", pht_pc, 32'h20);
        check("br_pht_tk", 32'(pht_taken), 32'h1);
        check("br_cnt1", 32'(br_cnt), 32'h1);
        check("mis_cnt1", 32'(mis_cnt), 32'h1);

        // Correctly predicted not-taken branch at 0x40
        tick(); drive_res(1, 0, 32'h40, 0, 32'h999, 32'h44); #3;
        check("nt_flush", 32'(flush), 32'h0);
        tick(); clear_res(); #3;
        check("nt_btb_vld", 32'(btb_vld), 32'h0);
        check("nt_pht_vld", 32'(pht_vld), 32'h1);
        check("nt_pht_pc", pht_pc, 32'h40);
        check("nt_pht_tk", 32'(pht_taken), 32'h0);
        check("nt_br_cnt", 32'(br_cnt), 32'h2);
        check("nt_mis_cnt", 32'(mis_cnt), 32'h1);

        // jal at 0x50: correctly predicted, then mispredicted
        tick(); drive_res(0, 1, 32'h50, 0, 32'h100, 32'h100); #3;
        check("jal_ok_flush", 32'(flush), 32'h0);
        tick(); clear_res(); #3;
        check("jal_ok_btb", 32'(btb_vld), 32'h0);
        check("jal_ok_pht", 32'(pht_vld), 32'h0);
        check("jal_ok_br_cnt", 32'(br_cnt), 32'h3);
        tick(); drive_res(0, 1, 32'h50, 0, 32'h100, 32'h54); #3;
        check("jal_mp_flush", 32'(flush), 32'h1);
        tick(); clear_res(); #3;
        check("jal_mp_pc", o_pc, 32'h100);
        check("jal_mp_btb", 32'(btb_vld), 32'h1);
        check("jal_mp_btb_pc", btb_pc, 32'h50);
        check("jal_mp_btb_addr", btb_addr, 32'h100);
        check("jal_mp_pht", 32'(pht_vld), 32'h0);
        check("jal_mp_mis_cnt", 32'(mis_cnt), 32'h2);

        // Branch-and-jump both set behaves as a jump: no PHT write
        tick(); drive_res(1, 1, 32'h70, 0, 32'h180, 32'h74); #3;
        check("both_flush", 32'(flush), 32'h1);
        tick(); clear_res(); #3;
        check("both_pc", o_pc, 32'h180);
        check("both_pht", 32'(pht_vld), 32'h0);

        // PC wrap from 0xFFFF_FFFC
        pred_follow = 0; pred_drv = 32'hFFFF_FFFC;
        tick(); pred_follow = 1; #3;
        check("wrap_pc_top", o_pc, 32'hFFFF_FFFC);
        tick(); #3;
        check("wrap_pc_zero", o_pc, 32'h0);
        drive_res(1, 0, 32'hFFFF_FFFC, 0, 32'h40, 32'h0); #1;
        check("wrap_res_ok", 32'(flush), 32'h0);
        tick(); drive_res(1, 0, 32'hFFFF_FFFC, 0, 32'h40, 32'h8); #1;
        check("wrap_res_mp", 32'(flush), 32'h1);
        tick(); clear_res(); #3;
        check("wrap_redirect", o_pc, 32'h0);

        // Mispredict during stall, reset next cycle
        tick(); fetch_rdy = 0; drive_res(1, 0, 32'h60, 1, 32'h300, 32'h64); #3;
        check("mr_flush", 32'(flush), 32'h1);
        check("mr_vld", 32'(fetch_vld), 32'h0);
        tick(); clear_res(); rst = 1; #3;
        check("mr_rst_vld", 32'(fetch_vld), 32'h0);
        tick(); rst = 0; fetch_rdy = 1; #3;
        check("mr_pc", o_pc, 32'h0);
        check("mr_btb", 32'(btb_vld), 32'h0);
        check("mr_pht", 32'(pht_vld), 32'h0);
        check("mr_br_cnt", 32'(br_cnt), 32'h0);
        check("mr_mis_cnt", 32'(mis_cnt), 32'h0);

        // Counter saturation with back-to-back mispredicting resolutions
        for (int i = 0; i < 20; i++) begin
            drive_res(1, 0, 32'h100 + 32'(i * 4), 1, 32'h800, 32'h4);
            tick();
        end
        clear_res(); #3;
        check("sat_br_cnt", 32'(br_cnt), 32'hF);
        check("sat_mis_cnt", 32'(mis_cnt), 32'hF);
        check("sat_btb_pulse", 32'(btb_vld), 32'h1);
        tick(); #3;
        check("sat_btb_end", 32'(btb_vld), 32'h0);

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            tick();
            rst         = ($urandom_range(0, 99) == 0);
            fetch_rdy   = ($urandom_range(0, 3) != 0);
            pred_follow = $urandom_range(0, 1);
            pred_taken  = $urandom_range(0, 1);
            pred_drv    = {$urandom_range(0, 32'hFFFF), 2'b00} | ($urandom_range(0, 7) == 0 ? 32'hFFFC_0000 : 32'h0);
            res_vld     = $urandom_range(0, 1);
            res_is_br   = $urandom_range(0, 1);
            res_is_jmp  = ($urandom_range(0, 3) == 0);
            res_taken   = $urandom_range(0, 1);
            res_pc      = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : {22'h0, $urandom_range(0, 255), 2'b00};
            res_target  = {20'h0, $urandom_range(0, 1023), 2'b00};
            sel         = 2'($urandom_range(0, 3));
            case (sel)
                2'd0:    res_pred_pc = res_target;
                2'd1:    res_pred_pc = res_pc + 32'd4;
                default: res_pred_pc = {20'h0, $urandom_range(0, 1023), 2'b00};
            endcase
        end
        tick(); clear_res(); rst = 0;
        tick(); tick(); #3;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
